// File: rtl/reg_pkg.sv
// Shared register-file types for the write-back scheduler and its arbiter.
package reg_pkg;

  localparam int unsigned ADR_W = 6;
  localparam int unsigned NARCH = 32;

  localparam logic [ADR_W-1:0] X0_ADR = 6'd0;
  localparam logic [ADR_W-1:0] PC_ADR = 6'd32;

  typedef logic [ADR_W-1:0] reg_adr_t;

  typedef enum logic {
    WB_SRC_0 = 1'b0,
    WB_SRC_1 = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input write-back arbiter. REG_WB_SCHED_RR_EN selects round-robin;
// otherwise WB1 has fixed priority over WB0.
module rr_arb2
  import reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr_q, ptr_d;
  logic    contested;

  assign contested = &req;

  always_comb begin
    gnt = req;
    if (contested) begin
`ifdef REG_WB_SCHED_RR_EN
      gnt = (ptr_q == WB_SRC_0) ? 2'b01 : 2'b10;
`else
      gnt = 2'b10;
`endif
    end
  end

  // Pointer names the preferred requester: the loser of the last contested cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (contested) begin
      ptr_d = gnt[0] ? WB_SRC_1 : WB_SRC_0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= WB_SRC_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-back scheduler and RAW/WAW scoreboard.
// Define REG_WB_SCHED_RR_EN for round-robin arbitration (default: WB1 priority).
module reg_wb_sched #(
  parameter int unsigned ADR_W = reg_pkg::ADR_W,
  parameter int unsigned NARCH = reg_pkg::NARCH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ISSUE_VALID_SD,
  input  logic [ADR_W-1:0] ISSUE_RD_SD,
  input  logic             ISSUE_WE_SD,
  input  logic [ADR_W-1:0] ISSUE_RS1_SD,
  input  logic [ADR_W-1:0] ISSUE_RS2_SD,
  output logic             STALL_SD,
  input  logic             FLUSH_SD,
  input  logic             WB0_VALID,
  input  logic [ADR_W-1:0] WB0_ADR,
  input  logic [31:0]      WB0_DATA,
  output logic             WB0_READY,
  input  logic             WB1_VALID,
  input  logic [ADR_W-1:0] WB1_ADR,
  input  logic [31:0]      WB1_DATA,
  output logic             WB1_READY,
  output logic [31:0]      WDATA_SW,
  output logic [ADR_W-1:0] WADR_SW,
  output logic             WENABLE_SW
);

  import reg_pkg::*;

  logic [1:0]       req, gnt;
  wb_src_e          src;
  logic             xfer;
  logic [ADR_W-1:0] xfer_adr;
  logic [31:0]      xfer_data;
  logic             wen_q, wen_d;
  logic [ADR_W-1:0] wadr_q, wadr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [NARCH-1:0] pending_q, pending_d;
  logic             issue_set;

  // Addresses at or above NARCH match no entry and so never report pending.
  function automatic logic is_pending(input logic [ADR_W-1:0] adr,
                                      input logic [NARCH-1:0] pend);
    is_pending = 1'b0;
    for (int unsigned i = 0; i < NARCH; i++) begin
      if (adr == ADR_W'(i)) is_pending = pend[i];
    end
  endfunction

  assign req = {WB1_VALID, WB0_VALID} & {2{reset_n}};

  rr_arb2 u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .gnt    (gnt)
  );

  assign WB0_READY = gnt[0];
  assign WB1_READY = gnt[1];
  assign xfer      = |gnt;
  assign src       = gnt[1] ? WB_SRC_1 : WB_SRC_0;

  always_comb begin
    xfer_adr  = WB0_ADR;
    xfer_data = WB0_DATA;
    if (src == WB_SRC_1) begin
      xfer_adr  = WB1_ADR;
      xfer_data = WB1_DATA;
    end
  end

  always_comb begin
    wen_d   = 1'b0;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      wen_d   = (xfer_adr != ADR_W'(X0_ADR));
      wadr_d  = xfer_adr;
      wdata_d = xfer_data;
    end
  end

  assign STALL_SD = ISSUE_VALID_SD & (is_pending(ISSUE_RS1_SD, pending_q) |
                                      is_pending(ISSUE_RS2_SD, pending_q) |
                                      (ISSUE_WE_SD & is_pending(ISSUE_RD_SD, pending_q)));

  assign issue_set = ISSUE_VALID_SD & ~STALL_SD & ISSUE_WE_SD;

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) begin
      for (int unsigned i = 0; i < NARCH; i++) begin
        if (wadr_q == ADR_W'(i)) pending_d[i] = 1'b0;
      end
    end
    if (issue_set) begin
      for (int unsigned i = 0; i < NARCH; i++) begin
        if (ISSUE_RD_SD == ADR_W'(i)) pending_d[i] = 1'b1;
      end
    end
    if (FLUSH_SD) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wen_q     <= 1'b0;
      wadr_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      wen_q     <= wen_d;
      wadr_q    <= wadr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign WENABLE_SW = wen_q;
  assign WADR_SW    = wadr_q;
  assign WDATA_SW   = wdata_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Bench for reg_wb_sched: per-cycle vector table with a write-port scoreboard.
// Expected grants follow REG_WB_SCHED_RR_EN when it is defined.
module tb_reg_wb_sched;

  logic        clk;
  logic        reset_n;
  logic        ISSUE_VALID_SD, ISSUE_WE_SD, FLUSH_SD, STALL_SD;
  logic [5:0]  ISSUE_RD_SD, ISSUE_RS1_SD, ISSUE_RS2_SD;
  logic        WB0_VALID, WB1_VALID, WB0_READY, WB1_READY;
  logic [5:0]  WB0_ADR, WB1_ADR, WADR_SW;
  logic [31:0] WB0_DATA, WB1_DATA, WDATA_SW;
  logic        WENABLE_SW;

  reg_wb_sched dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ISSUE_VALID_SD(ISSUE_VALID_SD),
    .ISSUE_RD_SD   (ISSUE_RD_SD),
    .ISSUE_WE_SD   (ISSUE_WE_SD),
    .ISSUE_RS1_SD  (ISSUE_RS1_SD),
    .ISSUE_RS2_SD  (ISSUE_RS2_SD),
    .STALL_SD      (STALL_SD),
    .FLUSH_SD      (FLUSH_SD),
    .WB0_VALID     (WB0_VALID),
    .WB0_ADR       (WB0_ADR),
    .WB0_DATA      (WB0_DATA),
    .WB0_READY     (WB0_READY),
    .WB1_VALID     (WB1_VALID),
    .WB1_ADR       (WB1_ADR),
    .WB1_DATA      (WB1_DATA),
    .WB1_READY     (WB1_READY),
    .WDATA_SW      (WDATA_SW),
    .WADR_SW       (WADR_SW),
    .WENABLE_SW    (WENABLE_SW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {WB1_READY, WB0_READY} on the 1st/2nd cycle of a contested pair.
`ifdef REG_WB_SCHED_RR_EN
  localparam logic [1:0] C0 = 2'b01;
  localparam logic [1:0] C1 = 2'b10;
`else
  localparam logic [1:0] C0 = 2'b10;
  localparam logic [1:0] C1 = 2'b10;
`endif

  typedef struct packed {
    logic        rst_n;
    logic        v0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic        iv;
    logic        iwe;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic        flush;
    logic [1:0]  rdy;
    logic        stall;
  } vec_t;

  typedef struct packed {
    logic        wen;
    logic [5:0]  adr;
    logic [31:0] data;
  } wr_t;

  vec_t        vecs[$];
  wr_t         exp_q[$];
  int          total;
  int          bad;
  logic [5:0]  last_adr;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst_n,
                     input logic v0, input logic [5:0] a0, input logic [31:0] d0,
                     input logic v1, input logic [5:0] a1, input logic [31:0] d1,
                     input logic iv, input logic iwe, input logic [5:0] rd,
                     input logic [5:0] rs1, input logic [5:0] rs2,
                     input logic flush, input logic [1:0] rdy, input logic stall);
    vec_t v;
    v.rst_n = rst_n; v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.iv = iv; v.iwe = iwe; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.flush = flush; v.rdy = rdy; v.stall = stall;
    vecs.push_back(v);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    wr_t e;
    wr_t got;
    reset_n        = v.rst_n;
    WB0_VALID      = v.v0; WB0_ADR = v.a0; WB0_DATA = v.d0;
    WB1_VALID      = v.v1; WB1_ADR = v.a1; WB1_DATA = v.d1;
    ISSUE_VALID_SD = v.iv; ISSUE_WE_SD = v.iwe;
    ISSUE_RD_SD    = v.rd; ISSUE_RS1_SD = v.rs1; ISSUE_RS2_SD = v.rs2;
    FLUSH_SD       = v.flush;
    #4;
    check($sformatf("row%0d_stall", idx), 64'(STALL_SD), 64'(v.stall));
    check($sformatf("row%0d_wb0_ready", idx), 64'(WB0_READY), 64'(v.rdy[0]));
    check($sformatf("row%0d_wb1_ready", idx), 64'(WB1_READY), 64'(v.rdy[1]));
    // Expected register-file port after this edge.
    if (!v.rst_n) begin
      last_adr  = '0;
      last_data = '0;
      e.wen = 1'b0;
    end else if (v.rdy[0]) begin
      last_adr  = v.a0;
      last_data = v.d0;
      e.wen = (v.a0 != 6'd0);
    end else if (v.rdy[1]) begin
      last_adr  = v.a1;
      last_data = v.d1;
      e.wen = (v.a1 != 6'd0);
    end else begin
      e.wen = 1'b0;
    end
    e.adr  = last_adr;
    e.data = last_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL row%0d_scoreboard: got empty queue want one entry", idx);
    end else begin
      e   = exp_q.pop_front();
      got.wen  = WENABLE_SW;
      got.adr  = WADR_SW;
      got.data = WDATA_SW;
      check($sformatf("row%0d_wenable", idx), 64'(got.wen), 64'(e.wen));
      check($sformatf("row%0d_wadr", idx), 64'(got.adr), 64'(e.adr));
      check($sformatf("row%0d_wdata", idx), 64'(got.data), 64'(e.data));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with a requester already valid: READY must stay low.
    reset_n = 1'b0;
    WB0_VALID = 1'b1; WB0_ADR = 6'd3; WB0_DATA = 32'h33;
    WB1_VALID = 1'b0; WB1_ADR = '0;   WB1_DATA = '0;
    ISSUE_VALID_SD = 1'b0; ISSUE_WE_SD = 1'b0; FLUSH_SD = 1'b0;
    ISSUE_RD_SD = '0; ISSUE_RS1_SD = '0; ISSUE_RS2_SD = '0;
    @(posedge clk); #1;
    check("reset_wb0_ready", 64'(WB0_READY), 64'(0));
    @(posedge clk); #1;
    check("reset_wenable", 64'(WENABLE_SW), 64'(0));
    check("reset_wadr", 64'(WADR_SW), 64'(0));
    check("reset_wdata", 64'(WDATA_SW), 64'(0));
    last_adr  = '0;
    last_data = '0;

    // Single transfer, then idle.
    add(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    add(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // Contention for four cycles.
    add(1, 1, 10, 32'hA0, 1, 11, 32'hB1, 0, 0, 0, 0, 0, 0, C0, 0);
    add(1, 1, 10, 32'hA0, 1, 11, 32'hB1, 0, 0, 0, 0, 0, 0, C1, 0);
    add(1, 1, 10, 32'hA0, 1, 11, 32'hB1, 0, 0, 0, 0, 0, 0, C0, 0);
    add(1, 1, 10, 32'hA0, 1, 11, 32'hB1, 0, 0, 0, 0, 0, 0, C1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // RAW on x7: stall until two cycles after its write-back transfer.
    add(1, 0, 0, 0, 0, 0, 0,       1, 1, 7, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 0,       1, 0, 0, 7, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 7, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 1, 7, 32'h77,  1, 0, 0, 7, 0, 0, 2'b10, 1);
    add(1, 0, 0, 0, 0, 0, 0,       1, 0, 0, 7, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 0,       1, 0, 0, 7, 0, 0, 2'b00, 0);
    // x9: issue set coincides with write-port clear; set wins.
    add(1, 1, 9, 32'h99, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b01, 0);
    add(1, 0, 0, 0,      0, 0, 0,  1, 1, 9, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0,      0, 0, 0,  1, 0, 0, 0, 9, 0, 2'b00, 1);
    add(1, 0, 0, 0,      0, 0, 0,  1, 1, 9, 0, 0, 0, 2'b00, 1);
    add(1, 1, 9, 32'h9A, 0, 0, 0,  1, 0, 0, 0, 9, 0, 2'b01, 1);
    add(1, 0, 0, 0,      0, 0, 0,  1, 0, 0, 0, 9, 0, 2'b00, 1);
    add(1, 0, 0, 0,      0, 0, 0,  1, 0, 0, 0, 9, 0, 2'b00, 0);
    // x0 and PC address: accepted, no scoreboard effect.
    add(1, 1, 0, 32'h1234, 0, 0, 0,         1, 1, 32, 0, 32, 0, 2'b01, 0);
    add(1, 0, 0, 0,        1, 32, 32'h5555, 1, 0, 0, 32, 0,  0, 2'b10, 0);
    add(1, 0, 0, 0,        0, 0, 0,         0, 0, 0, 0, 0,   0, 2'b00, 0);
    // Flush clears x3/x4 and drops the same-cycle set of x5; WB still completes.
    add(1, 0, 0, 0,      0, 0, 0, 1, 1, 3, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0,      0, 0, 0, 1, 1, 4, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0,      0, 0, 0, 1, 0, 0, 3, 4, 0, 2'b00, 1);
    add(1, 1, 6, 32'h66, 0, 0, 0, 1, 1, 5, 0, 0, 1, 2'b01, 0);
    add(1, 0, 0, 0,      0, 0, 0, 1, 0, 0, 3, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0,      0, 0, 0, 1, 0, 0, 5, 4, 0, 2'b00, 0);
    // Reset while a write is staged and x13 is pending; pointer returns to WB0.
    add(1, 0, 0, 0,         0, 0, 0,         1, 1, 13, 0, 0,  0, 2'b00, 0);
    add(1, 1, 12, 32'hC0C0, 1, 14, 32'hE0E0, 1, 0, 0, 13, 0, 0, C0, 1);
    add(0, 1, 12, 32'hC0C0, 1, 14, 32'hE0E0, 1, 0, 0, 13, 0, 0, 2'b00, 1);
    add(1, 1, 12, 32'hC0C0, 1, 14, 32'hE0E0, 1, 0, 0, 13, 0, 0, C0, 0);
    add(1, 0, 0, 0,         0, 0, 0,         0, 0, 0, 0, 0,   0, 2'b00, 0);

    foreach (vecs[i]) begin
      run_row(i, vecs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
